// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: request-to-send, 11-clock frame, device ack check.
// Optional PS2_TX_TIMEOUT_EN adds an abort if the device stops clocking after release.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned START_CYCLES   = 20,
   parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   output logic       CLK_MOUSE_OE,
   output logic       DATA_MOUSE_OE,
   input  logic       SEND_BYTE,
   input  logic [7:0] BYTE_TO_SEND,
   output logic       BUSY,
   output logic       BYTE_SENT,
   output logic       TX_ERROR
);

   localparam int unsigned DLY_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
   localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t            state_q, state_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [3:0]        bit_q, bit_d;
   logic [10:0]       sh_q, sh_d;
   logic              err_q, err_d;
   logic              sent_q, sent_d;
   logic              txerr_q, txerr_d;
   logic              clk_s1_q, clk_s2_q, clk_prev_q;
   logic              dat_s1_q, dat_s2_q;
   logic              ps2_fall;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]   to_q, to_d;
`endif

   assign ps2_fall = clk_prev_q & ~clk_s2_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         dly_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '1;
         err_q      <= 1'b0;
         sent_q     <= 1'b0;
         txerr_q    <= 1'b0;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
         to_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         dly_q      <= dly_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         err_q      <= err_d;
         sent_q     <= sent_d;
         txerr_q    <= txerr_d;
         clk_s1_q   <= CLK_MOUSE_IN;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= DATA_MOUSE_IN;
         dat_s2_q   <= dat_s1_q;
`ifdef PS2_TX_TIMEOUT_EN
         to_q       <= to_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      err_d   = err_q;
      sent_d  = 1'b0;
      txerr_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_d    = to_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (SEND_BYTE) begin
               // LSB is the start bit, held low until the device's first falling edge
               sh_d    = {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND, 1'b0};
               dly_d   = '0;
               err_d   = 1'b0;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (dly_q == DLY_W'(INHIBIT_CYCLES - 1)) begin
               dly_d   = '0;
               state_d = S_START;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_START: begin
            if (dly_q == DLY_W'(START_CYCLES - 1)) begin
               dly_d   = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
`ifdef PS2_TX_TIMEOUT_EN
               to_d    = '0;
`endif
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (ps2_fall) begin
               sh_d = {1'b1, sh_q[10:1]};
               if (bit_q == 4'd9) begin
                  state_d = S_ACK;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_ACK: begin
            if (ps2_fall) begin
               if (dat_s2_q) begin
                  txerr_d = 1'b1;
                  err_d   = 1'b1;
               end
               state_d = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (clk_s2_q && dat_s2_q) begin
               sent_d  = ~err_q;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Abort overrides any transition above; a nack already reported is not reported twice
      if ((state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE)) begin
         if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            txerr_d = ~err_q;
            sent_d  = 1'b0;
            err_d   = 1'b0;
         end else begin
            to_d = to_q + 1'b1;
         end
      end
`endif
   end

   assign CLK_MOUSE_OE  = (state_q == S_INHIBIT) || (state_q == S_START);
   assign DATA_MOUSE_OE = (state_q == S_START) || ((state_q == S_SHIFT) && !sh_q[0]);
   assign BUSY          = (state_q != S_IDLE);
   assign BYTE_SENT     = sent_q;
   assign TX_ERROR      = txerr_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Timeout case is built only when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;

   localparam int unsigned INH = 200;
   localparam int unsigned STC = 20;
   localparam int unsigned TOC = 3000;
   localparam int unsigned H   = 20;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       SEND_BYTE = 1'b0;
   logic [7:0] BYTE_TO_SEND = 8'h00;
   logic       CLK_MOUSE_OE, DATA_MOUSE_OE, BUSY, BYTE_SENT, TX_ERROR;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       clk_line, data_line;

   int pass_cnt = 0;
   int total    = 0;

   always #5 CLK = ~CLK;

   assign clk_line  = dev_clk & ~CLK_MOUSE_OE;
   assign data_line = dev_data & ~DATA_MOUSE_OE;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_CYCLES  (STC),
      .TIMEOUT_CYCLES(TOC)
   ) u_dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .CLK_MOUSE_IN (clk_line),
      .DATA_MOUSE_IN(data_line),
      .CLK_MOUSE_OE (CLK_MOUSE_OE),
      .DATA_MOUSE_OE(DATA_MOUSE_OE),
      .SEND_BYTE    (SEND_BYTE),
      .BYTE_TO_SEND (BYTE_TO_SEND),
      .BUSY         (BUSY),
      .BYTE_SENT    (BYTE_SENT),
      .TX_ERROR     (TX_ERROR)
   );

   int   sent_cnt = 0;
   int   err_cnt  = 0;
   int   both_cnt = 0;
   logic busy_last = 1'b0;
   logic busy_at_sent = 1'b1;
   logic busy_prev_at_sent = 1'b0;

   always @(negedge CLK) begin
      if (BYTE_SENT) begin
         sent_cnt          <= sent_cnt + 1;
         busy_at_sent      <= BUSY;
         busy_prev_at_sent <= busy_last;
      end
      if (TX_ERROR) err_cnt <= err_cnt + 1;
      if (BYTE_SENT && TX_ERROR) both_cnt <= both_cnt + 1;
      busy_last <= BUSY;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Strobe a request, then measure how long the host holds CLK low and CLK-only low
   task automatic start_send(input logic [7:0] b, output int n_low, output int n_inh);
      SEND_BYTE    = 1'b1;
      BYTE_TO_SEND = b;
      tick;
      SEND_BYTE = 1'b0;
      n_low = 0;
      n_inh = 0;
      while (CLK_MOUSE_OE && n_low < 5000) begin
         if (!DATA_MOUSE_OE) n_inh++;
         n_low++;
         tick;
      end
   endtask

   // Device generates 11 clocks; samples host data on rising edges 1..10, drives ack before fall 11
   task automatic dev_frame(input logic ack_bit, input int inject_at, input int rst_at,
                            output logic [9:0] cap, output logic aborted, output logic snap);
      cap     = '0;
      aborted = 1'b0;
      snap    = 1'b0;
      repeat (H) tick;
      for (int i = 1; i <= 11; i++) begin
         dev_clk = 1'b0;
         repeat (4) tick;
         if (i == rst_at) begin
            snap  = DATA_MOUSE_OE;
            RESET = 1'b1;
            tick;
            RESET    = 1'b0;
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            aborted  = 1'b1;
            return;
         end
         if (i == 11) snap = CLK_MOUSE_OE | DATA_MOUSE_OE;
         if (i == inject_at) begin
            SEND_BYTE    = 1'b1;
            BYTE_TO_SEND = 8'hAA;
         end
         tick;
         SEND_BYTE = 1'b0;
         repeat (H - 5) tick;
         dev_clk = 1'b1;
         if (i <= 10) cap[i-1] = data_line;
         if (i == 11) dev_data = 1'b1;
         repeat (H / 2) tick;
         if (i == 10) dev_data = ack_bit;
         repeat (H - H / 2) tick;
      end
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (BUSY && n < 200) begin
         n++;
         tick;
      end
   endtask

   initial begin
      int         n_low, n_inh, s0, e0, n;
      logic [9:0] cap;
      logic       ab, snap;

      repeat (3) tick;
      RESET = 1'b0;
      tick;
      chk("rst_clk_oe", CLK_MOUSE_OE, 0);
      chk("rst_data_oe", DATA_MOUSE_OE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_sent", BYTE_SENT, 0);
      chk("rst_err", TX_ERROR, 0);

      // 0xF4 acked
      s0 = sent_cnt; e0 = err_cnt;
      start_send(8'hF4, n_low, n_inh);
      chk("f4_clk_low_len", n_low, INH + STC);
      chk("f4_inhibit_len", n_inh, INH);
      chk("f4_busy_mid", BUSY, 1);
      dev_frame(1'b0, 0, 0, cap, ab, snap);
      chk("f4_data", cap[7:0], 8'hF4);
      chk("f4_parity", cap[8], 0);
      chk("f4_stop", cap[9], 1);
      chk("f4_ack_released", snap, 0);
      wait_idle;
      chk("f4_busy_end", BUSY, 0);
      chk("f4_sent_pulses", sent_cnt - s0, 1);
      chk("f4_err_pulses", err_cnt - e0, 0);
      chk("f4_busy_with_sent", busy_at_sent, 0);
      chk("f4_busy_before_sent", busy_prev_at_sent, 1);

      // 0xFF acked, parity 1
      repeat (10) tick;
      s0 = sent_cnt; e0 = err_cnt;
      start_send(8'hFF, n_low, n_inh);
      dev_frame(1'b0, 0, 0, cap, ab, snap);
      wait_idle;
      chk("ff_frame", cap, 10'h3FF);
      chk("ff_sent_pulses", sent_cnt - s0, 1);
      chk("ff_err_pulses", err_cnt - e0, 0);

      // 0x00 nacked
      repeat (10) tick;
      s0 = sent_cnt; e0 = err_cnt;
      start_send(8'h00, n_low, n_inh);
      dev_frame(1'b1, 0, 0, cap, ab, snap);
      wait_idle;
      chk("nack_frame", cap, 10'h300);
      chk("nack_err_pulses", err_cnt - e0, 1);
      chk("nack_sent_pulses", sent_cnt - s0, 0);
      chk("nack_busy_end", BUSY, 0);

      // 0xF3 with a 0xAA request injected mid-frame
      repeat (10) tick;
      s0 = sent_cnt; e0 = err_cnt;
      start_send(8'hF3, n_low, n_inh);
      dev_frame(1'b0, 3, 0, cap, ab, snap);
      wait_idle;
      chk("f3_frame", cap, 10'h3F3);
      chk("f3_sent_pulses", sent_cnt - s0, 1);
      n = 0;
      repeat (INH + 100) begin
         if (BUSY || CLK_MOUSE_OE) n++;
         tick;
      end
      chk("inject_ignored", n, 0);

      // Reset at falling edge 5 of 0x0F (D4 = 0 so DATA is driven low)
      s0 = sent_cnt; e0 = err_cnt;
      start_send(8'h0F, n_low, n_inh);
      dev_frame(1'b0, 0, 5, cap, ab, snap);
      chk("rst_mid_aborted", ab, 1);
      chk("rst_mid_data_before", snap, 1);
      chk("rst_mid_clk_oe", CLK_MOUSE_OE, 0);
      chk("rst_mid_data_oe", DATA_MOUSE_OE, 0);
      chk("rst_mid_busy", BUSY, 0);
      repeat (10) tick;
      chk("rst_mid_no_sent", sent_cnt - s0, 0);
      chk("rst_mid_no_err", err_cnt - e0, 0);

      s0 = sent_cnt; e0 = err_cnt;
      start_send(8'hF4, n_low, n_inh);
      dev_frame(1'b0, 0, 0, cap, ab, snap);
      wait_idle;
      chk("post_rst_frame", cap, 10'h2F4);
      chk("post_rst_sent", sent_cnt - s0, 1);
      chk("post_rst_err", err_cnt - e0, 0);

`ifdef PS2_TX_TIMEOUT_EN
      // Device never clocks after release
      repeat (10) tick;
      e0 = err_cnt;
      start_send(8'hF4, n_low, n_inh);
      n = 0;
      while (!TX_ERROR && n < TOC + 1000) begin
         n++;
         tick;
      end
      chk("to_latency", n, TOC);
      chk("to_clk_oe", CLK_MOUSE_OE, 0);
      chk("to_data_oe", DATA_MOUSE_OE, 0);
      chk("to_busy", BUSY, 0);
      tick;
      chk("to_err_pulses", err_cnt - e0, 1);
`endif

      tick;
      chk("never_both_pulses", both_cnt, 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
